spi_slave_rx_tx: RTL and testbench
==================================

Name: spi_slave_rx_tx

Overview:
- SPI responder (mode 0, CPOL=0/CPHA=0, MSB first) running entirely in the system clock domain.
- Oversamples the external sck, cs_n and mosi pins through synchronisers and detects edges. Shifts received bytes out to the fabric and shifts fabric-supplied bytes onto miso.
- Serves as the far end for the SPI master and its divided clock: it emulates a sensor (e.g. BMP280 register model) in simulation and on-board loopback, and is reusable as a generic SPI peripheral port.

Parameters:
- DATA_W, 8, bits per SPI word; shift registers and bit counter are sized from it.
- SYNC_STAGES, 2, flip-flop stages on each of sck, cs_n and mosi (minimum 2).

Ports:
- clk_in  in  1  system clock; must be at least 8x the sck frequency.
- n_rst  in  1  asynchronous active-low reset.
- sck  in  1  SPI clock from the master, asynchronous to clk_in.
- cs_n  in  1  chip select from the master, active low, asynchronous.
- mosi  in  1  serial data from the master.
- miso  out  1  serial data to the master.
- miso_oe  out  1  output enable for the miso pad buffer; 1 while the frame is selected.
- tx_data  in  DATA_W  next word to transmit, sampled on tx_load.
- tx_load  out  1  one-cycle pulse: tx_data captured this cycle.
- rx_data  out  DATA_W  last complete received word.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- frame_start  out  1  one-cycle pulse on synchronised cs_n falling edge.
- frame_end  out  1  one-cycle pulse on synchronised cs_n rising edge.
- busy  out  1  high while synchronised cs_n is low.

Behaviour:
- Interface: one clock, clk_in; reset is asynchronous and active-low on n_rst. All state is clocked on rising clk_in.
- Reset state:
  - Synchroniser registers for sck and mosi = 0; cs_n synchronisers = 1 (deselected).
  - Shift registers = 0, bit_cnt = 0, rx_data = 0.
  - miso = 1, miso_oe = 0, busy = 0.
  - All pulse outputs = 0.
- Synchronisation:
  - Each pin passes through SYNC_STAGES flip-flops, then one extra "previous" register per pin for edge detection.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Edge strobe latency is SYNC_STAGES+1 clk_in cycles after the pin transition (±1 cycle for async sampling).
- States: IDLE (cs synced high) and ACTIVE (cs synced low). busy = ACTIVE; miso_oe = busy.
- IDLE -> ACTIVE on the cs fall strobe, in the same cycle:
  - frame_start = 1, tx_load = 1.
  - tx_shift <= tx_data; miso <= tx_data[DATA_W-1].
  - bit_cnt <= 0.
- ACTIVE, on sck rise strobe:
  - rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync}.
  - bit_cnt increments and wraps DATA_W-1 -> 0.
  - On the wrap: rx_data <= the assembled word and rx_valid pulses in that same cycle.
- ACTIVE, on sck fall strobe:
  - If bit_cnt == 0 (word boundary): tx_shift <= tx_data, tx_load pulses, miso <= tx_data[DATA_W-1].
  - Otherwise: tx_shift shifts left and miso <= the next bit.
  - The fall that follows the first rise has bit_cnt = 1, so it shifts.
- ACTIVE -> IDLE on the cs rise strobe:
  - frame_end pulses; miso = 1, miso_oe = 0; bit_cnt <= 0.
  - A partial word is discarded: no rx_valid, rx_data unchanged.
- sck edges while IDLE are ignored: no shift, no counter change.
- Simultaneous cs rise and sck edge strobes in one cycle: cs wins and the sck edge is ignored.
- Reset asserted mid-frame: immediate return to the reset state. After reset release with cs_n still low, the block stays IDLE until a fresh cs_n falling edge.
- rx_valid and tx_load are never asserted for more than one cycle per event.
- Timing requirement on the master: sck high and low times each ≥ 4 clk_in periods; cs_n setup to the first sck rise ≥ 4 clk_in periods.

Test Plan:
- Reset with pins idle, then release -> miso=1, miso_oe=0, busy=0, all pulses 0, rx_data=0x00.
- cs_n low, tx_data=0xA5, master sends 0x3C on mosi at sck = clk_in/16:
  - frame_start and tx_load pulse once.
  - Master samples 0xA5 on miso.
  - rx_valid pulses once after the 8th rising edge with rx_data=0x3C.
- Two-word frame: mosi 0xD0 then 0x00; tx_data changed to 0x58 after the first tx_load:
  - Two rx_valid pulses (0xD0, 0x00).
  - Second tx_load on the 8th sck fall.
  - Master reads 0xA5 then 0x58.
- cs_n raised after 5 sck clocks -> frame_end pulses, no rx_valid, rx_data keeps its old value; the next frame starts with bit_cnt=0 and receives 0x96 correctly.
- sck toggled 8 times with cs_n high -> no rx_valid, no tx_load, miso=1, miso_oe=0.
- n_rst pulsed low after 3 bits of a frame with cs_n held low:
  - All outputs return to reset values.
  - Remaining sck edges are ignored until cs_n rises and falls again.

Source files
------------

// File: rtl/spi_slave_rx_tx_if.sv
// Pin-side and fabric-side signals of the SPI responder, bundled for port hookup.
// The slave modport is the responder's view; the master modport is the driver's view.
interface spi_slave_rx_tx_if #(
  parameter int DATA_W = 8
);
  logic              sck;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_start;
  logic              frame_end;
  logic              busy;

  modport slave (
    input  sck, cs_n, mosi, tx_data,
    output miso, miso_oe, tx_load, rx_data, rx_valid, frame_start, frame_end, busy
  );

  modport master (
    output sck, cs_n, mosi, tx_data,
    input  miso, miso_oe, tx_load, rx_data, rx_valid, frame_start, frame_end, busy
  );
endinterface

// File: rtl/spi_slave_rx_tx.sv
// SPI mode-0 responder, MSB first, fully in the clk_in domain: pins are oversampled
// through synchronisers and sck/cs_n edges are detected as single-cycle strobes.
module spi_slave_rx_tx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_in,
  input  logic                 n_rst,
  spi_slave_rx_tx_if.slave     bus
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_r, cs_sync_r, mosi_sync_r;
  logic                   sck_prev_r, cs_prev_r;
  logic [SYNC_STAGES:0]   fill_r;
  logic                   armed_r;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise_s, sck_fall_s, cs_rise_s, cs_fall_s;

  state_t                 state_r, state_nxt_s;
  logic [DATA_W-1:0]      tx_shift_r, tx_shift_nxt_s;
  logic [DATA_W-1:0]      rx_shift_r, rx_shift_nxt_s;
  logic [DATA_W-1:0]      rx_data_r, rx_data_nxt_s;
  logic [CNT_W-1:0]       bit_cnt_r, bit_cnt_nxt_s;
  logic                   miso_r, miso_nxt_s;
  logic                   busy_r;
  logic                   rx_valid_r, rx_valid_nxt_s;
  logic                   tx_load_r, tx_load_nxt_s;
  logic                   frame_start_r, frame_start_nxt_s;
  logic                   frame_end_r, frame_end_nxt_s;

  assign sck_s      = sck_sync_r[SYNC_STAGES-1];
  assign cs_s       = cs_sync_r[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
  assign sck_rise_s = sck_s & ~sck_prev_r;
  assign sck_fall_s = ~sck_s & sck_prev_r;
  assign cs_rise_s  = cs_s & ~cs_prev_r;
  assign cs_fall_s  = ~cs_s & cs_prev_r;

  // Pin synchronisers and edge-detect history. A frame may only open once cs_n has been
  // genuinely sampled high, so a cs_n held low through reset release is not taken as a fall.
  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      sck_sync_r  <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sck_prev_r  <= 1'b0;
      cs_prev_r   <= 1'b1;
      fill_r      <= {(SYNC_STAGES+1){1'b0}};
      armed_r     <= 1'b0;
    end else begin
      sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], bus.sck};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], bus.mosi};
      sck_prev_r  <= sck_s;
      cs_prev_r   <= cs_s;
      fill_r      <= {fill_r[SYNC_STAGES-1:0], 1'b1};
      armed_r     <= armed_r | (fill_r[SYNC_STAGES] & cs_s);
    end
  end

  // Frame FSM plus shift/count datapath; cs edges take priority over sck edges.
  always_comb begin
    state_nxt_s       = state_r;
    tx_shift_nxt_s    = tx_shift_r;
    rx_shift_nxt_s    = rx_shift_r;
    rx_data_nxt_s     = rx_data_r;
    bit_cnt_nxt_s     = bit_cnt_r;
    miso_nxt_s        = miso_r;
    rx_valid_nxt_s    = 1'b0;
    tx_load_nxt_s     = 1'b0;
    frame_start_nxt_s = 1'b0;
    frame_end_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        miso_nxt_s = 1'b1;
        if (cs_fall_s && armed_r) begin
          state_nxt_s       = ST_ACTIVE;
          frame_start_nxt_s = 1'b1;
          tx_load_nxt_s     = 1'b1;
          tx_shift_nxt_s    = bus.tx_data;
          miso_nxt_s        = bus.tx_data[DATA_W-1];
          bit_cnt_nxt_s     = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise_s) begin
          state_nxt_s     = ST_IDLE;
          frame_end_nxt_s = 1'b1;
          miso_nxt_s      = 1'b1;
          bit_cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (sck_rise_s) begin
          rx_shift_nxt_s = {rx_shift_r[DATA_W-2:0], mosi_s};
          if (bit_cnt_r == CNT_W'(DATA_W-1)) begin
            bit_cnt_nxt_s  = {CNT_W{1'b0}};
            rx_data_nxt_s  = {rx_shift_r[DATA_W-2:0], mosi_s};
            rx_valid_nxt_s = 1'b1;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
          end
        end else if (sck_fall_s) begin
          if (bit_cnt_r == {CNT_W{1'b0}}) begin
            tx_shift_nxt_s = bus.tx_data;
            tx_load_nxt_s  = 1'b1;
            miso_nxt_s     = bus.tx_data[DATA_W-1];
          end else begin
            tx_shift_nxt_s = {tx_shift_r[DATA_W-2:0], 1'b0};
            miso_nxt_s     = tx_shift_r[DATA_W-2];
          end
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        miso_nxt_s  = 1'b1;
      end
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      state_r       <= ST_IDLE;
      tx_shift_r    <= {DATA_W{1'b0}};
      rx_shift_r    <= {DATA_W{1'b0}};
      rx_data_r     <= {DATA_W{1'b0}};
      bit_cnt_r     <= {CNT_W{1'b0}};
      miso_r        <= 1'b1;
      busy_r        <= 1'b0;
      rx_valid_r    <= 1'b0;
      tx_load_r     <= 1'b0;
      frame_start_r <= 1'b0;
      frame_end_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      tx_shift_r    <= tx_shift_nxt_s;
      rx_shift_r    <= rx_shift_nxt_s;
      rx_data_r     <= rx_data_nxt_s;
      bit_cnt_r     <= bit_cnt_nxt_s;
      miso_r        <= miso_nxt_s;
      busy_r        <= (state_nxt_s == ST_ACTIVE);
      rx_valid_r    <= rx_valid_nxt_s;
      tx_load_r     <= tx_load_nxt_s;
      frame_start_r <= frame_start_nxt_s;
      frame_end_r   <= frame_end_nxt_s;
    end
  end

  assign bus.miso        = miso_r;
  assign bus.miso_oe     = busy_r;
  assign bus.busy        = busy_r;
  assign bus.rx_data     = rx_data_r;
  assign bus.rx_valid    = rx_valid_r;
  assign bus.tx_load     = tx_load_r;
  assign bus.frame_start = frame_start_r;
  assign bus.frame_end   = frame_end_r;
endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Directed bench for spi_slave_rx_tx: an SPI master model drives frames at sck = clk_in/16;
// expected received words go into a queue that a monitor pops on every rx_valid.
module tb_spi_slave_rx_tx;
  logic clk_in = 1'b0;
  logic n_rst  = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   rx_cnt = 0, tl_cnt = 0, fs_cnt = 0, fe_cnt = 0;
  logic [7:0] rx_exp_q[$];
  logic [7:0] got;
  logic       rv_prev = 1'b0, tl_prev = 1'b0;
  int         rx0, tl0, fs0, fe0;

  spi_slave_rx_tx_if #(.DATA_W(8)) bus ();

  spi_slave_rx_tx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk_in (clk_in),
    .n_rst  (n_rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pop expected word on each rx_valid and count single-cycle pulses.
  initial begin
    forever begin
      @(negedge clk_in);
      if (bus.rx_valid) begin
        rx_cnt++;
        if (rx_exp_q.size() == 0) begin
          chk("rx_unexpected", 32'(bus.rx_data), 32'hFFFF_FFFF);
        end else begin
          chk("rx_data", 32'(bus.rx_data), 32'(rx_exp_q.pop_front()));
        end
        if (rv_prev) chk("rx_valid_width", 32'd2, 32'd1);
      end
      if (bus.tx_load) begin
        tl_cnt++;
        if (tl_prev) chk("tx_load_width", 32'd2, 32'd1);
      end
      if (bus.frame_start) fs_cnt++;
      if (bus.frame_end)   fe_cnt++;
      rv_prev = bus.rx_valid;
      tl_prev = bus.tx_load;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Master model: shifts nbits of mo out MSB first, samples miso on each sck rise.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = mo[7-i];
      wait_clk(8);
      bus.sck = 1'b1;
      mi = {mi[6:0], bus.miso};
      wait_clk(8);
      bus.sck = 1'b0;
    end
  endtask

  task automatic cs_low;
    bus.cs_n = 1'b0;
    wait_clk(16);
  endtask

  task automatic cs_high;
    wait_clk(8);
    bus.cs_n = 1'b1;
    wait_clk(16);
  endtask

  initial begin
    bus.sck = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0; bus.tx_data = 8'h00;
    wait_clk(5);
    n_rst = 1'b1;
    wait_clk(5);
    chk("rst_miso",    32'(bus.miso),        32'd1);
    chk("rst_oe",      32'(bus.miso_oe),     32'd0);
    chk("rst_busy",    32'(bus.busy),        32'd0);
    chk("rst_rx_data", 32'(bus.rx_data),     32'h00);
    chk("rst_pulses",  32'({bus.rx_valid, bus.tx_load, bus.frame_start, bus.frame_end}), 32'd0);

    // Single word: slave sends 0xA5, receives 0x3C.
    bus.tx_data = 8'hA5;
    rx_exp_q.push_back(8'h3C);
    rx0 = rx_cnt; tl0 = tl_cnt; fs0 = fs_cnt; fe0 = fe_cnt;
    cs_low();
    chk("f1_busy",   32'(bus.busy),    32'd1);
    chk("f1_oe",     32'(bus.miso_oe), 32'd1);
    chk("f1_fs",     32'(fs_cnt - fs0), 32'd1);
    chk("f1_tl_start", 32'(tl_cnt - tl0), 32'd1);
    xfer(8'h3C, 8, got);
    chk("f1_miso_word", 32'(got), 32'hA5);
    cs_high();
    chk("f1_fe",     32'(fe_cnt - fe0), 32'd1);
    chk("f1_rx_cnt", 32'(rx_cnt - rx0), 32'd1);
    chk("f1_idle_busy", 32'(bus.busy), 32'd0);
    chk("f1_idle_miso", 32'(bus.miso), 32'd1);

    // Two-word frame: tx 0xA5 then 0x58, rx 0xD0 then 0x00.
    bus.tx_data = 8'hA5;
    rx_exp_q.push_back(8'hD0);
    rx_exp_q.push_back(8'h00);
    rx0 = rx_cnt; tl0 = tl_cnt;
    cs_low();
    chk("f2_tl_first", 32'(tl_cnt - tl0), 32'd1);
    bus.tx_data = 8'h58;
    xfer(8'hD0, 8, got);
    chk("f2_miso_w0", 32'(got), 32'hA5);
    wait_clk(6);
    chk("f2_tl_second", 32'(tl_cnt - tl0), 32'd2);
    xfer(8'h00, 8, got);
    chk("f2_miso_w1", 32'(got), 32'h58);
    cs_high();
    chk("f2_rx_cnt", 32'(rx_cnt - rx0), 32'd2);

    // Partial word discarded, then a clean frame receiving 0x96.
    rx0 = rx_cnt; fe0 = fe_cnt;
    cs_low();
    xfer(8'hFF, 5, got);
    cs_high();
    chk("part_fe",      32'(fe_cnt - fe0), 32'd1);
    chk("part_rx_cnt",  32'(rx_cnt - rx0), 32'd0);
    chk("part_rx_data", 32'(bus.rx_data),  32'h00);
    bus.tx_data = 8'hC3;
    rx_exp_q.push_back(8'h96);
    cs_low();
    xfer(8'h96, 8, got);
    chk("part_next_miso", 32'(got), 32'hC3);
    cs_high();
    chk("part_next_rx", 32'(rx_cnt - rx0), 32'd1);

    // sck activity with cs_n high must be ignored.
    rx0 = rx_cnt; tl0 = tl_cnt;
    for (int i = 0; i < 8; i++) begin
      bus.sck = 1'b1; wait_clk(8);
      bus.sck = 1'b0; wait_clk(8);
      chk("idle_miso", 32'(bus.miso),    32'd1);
      chk("idle_oe",   32'(bus.miso_oe), 32'd0);
    end
    chk("idle_rx_cnt", 32'(rx_cnt - rx0), 32'd0);
    chk("idle_tl_cnt", 32'(tl_cnt - tl0), 32'd0);

    // Reset mid-frame with cs_n held low: stays idle until a fresh cs_n fall.
    bus.tx_data = 8'hA5;
    cs_low();
    xfer(8'hFF, 3, got);
    n_rst = 1'b0;
    wait_clk(3);
    chk("mid_rst_miso", 32'(bus.miso),    32'd1);
    chk("mid_rst_oe",   32'(bus.miso_oe), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy),    32'd0);
    chk("mid_rst_rx",   32'(bus.rx_data), 32'h00);
    n_rst = 1'b1;
    rx0 = rx_cnt; tl0 = tl_cnt; fs0 = fs_cnt; fe0 = fe_cnt;
    wait_clk(8);
    xfer(8'hFF, 5, got);
    chk("post_rst_busy", 32'(bus.busy),     32'd0);
    chk("post_rst_oe",   32'(bus.miso_oe),  32'd0);
    chk("post_rst_miso", 32'(got),          32'h1F);
    chk("post_rst_rx",   32'(rx_cnt - rx0), 32'd0);
    chk("post_rst_tl",   32'(tl_cnt - tl0), 32'd0);
    chk("post_rst_fs",   32'(fs_cnt - fs0), 32'd0);
    cs_high();
    chk("post_rst_fe",   32'(fe_cnt - fe0), 32'd0);
    rx_exp_q.push_back(8'h3C);
    cs_low();
    chk("refresh_fs", 32'(fs_cnt - fs0), 32'd1);
    xfer(8'h3C, 8, got);
    chk("refresh_miso", 32'(got), 32'hA5);
    cs_high();
    chk("refresh_rx", 32'(rx_cnt - rx0), 32'd1);

    chk("queue_drained", 32'(rx_exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
